// File: rtl/lc3_control_fsm.sv
// Moore sequencer for the LC-3 lab datapath: fetch, decode and execute of the
// instruction subset, with a programmable memory-strobe hold time.
module lc3_control_fsm #(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] State_dbg
);

  localparam int CW = $clog2(MEM_WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT_CYCLES - 1);

  typedef enum logic [4:0] {
    HALTED = 5'd0,  S18 = 5'd1,  S33 = 5'd2,  S35 = 5'd3,  S32 = 5'd4,
    S1     = 5'd5,  S5  = 5'd6,  S9  = 5'd7,  S0  = 5'd8,  S22 = 5'd9,
    S12    = 5'd10, S4  = 5'd11, S21 = 5'd12, S6  = 5'd13, S7  = 5'd14,
    S25    = 5'd15, S27 = 5'd16, S23 = 5'd17, S16 = 5'd18, P1  = 5'd19,
    P2     = 5'd20
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_done_s;
  logic          mem_state_s;

  assign mem_done_s  = (cnt_q == CNT_LAST);
  assign mem_state_s = (state_q == S33) || (state_q == S25) || (state_q == S16);

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED: if (Run) state_d = S18; else state_d = HALTED;
      S18:    state_d = S33;
      S33:    if (mem_done_s) state_d = S35; else state_d = S33;
      S35:    state_d = S32;
      S32: begin
        case (Opcode)
          4'b0001: state_d = S1;
          4'b0101: state_d = S5;
          4'b1001: state_d = S9;
          4'b0000: state_d = S0;
          4'b1100: state_d = S12;
          4'b0100: state_d = S4;
          4'b0110: state_d = S6;
          4'b0111: state_d = S7;
          4'b1101: state_d = P1;
          default: state_d = S18;
        endcase
      end
      S0:     if (BEN) state_d = S22; else state_d = S18;
      S4:     state_d = S21;
      S6:     state_d = S25;
      S7:     state_d = S23;
      S25:    if (mem_done_s) state_d = S27; else state_d = S25;
      S23:    state_d = S16;
      S16:    if (mem_done_s) state_d = S18; else state_d = S16;
      P1:     if (Continue) state_d = P2; else state_d = P1;
      // P2 waits for release so a long press advances exactly one instruction.
      P2:     if (!Continue) state_d = S18; else state_d = P2;
      default: state_d = S18;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if (mem_state_s)
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= HALTED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = 2'b00; ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; DRMUX = 1'b0;
    SR1MUX = 1'b0; SR2MUX = IR_5; ALUK = 2'b00; MIO_EN = 1'b0;
    Mem_OE = 1'b0; Mem_WE = 1'b0; State_dbg = state_q;
    case (state_q)
      S18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
      S33, S25: begin Mem_OE = 1'b1; MIO_EN = 1'b1; LD_MDR = mem_done_s; end
      S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S32: LD_BEN = 1'b1;
      S1:  begin SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = 2'b00; end
      S5:  begin SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = 2'b01; end
      S9:  begin SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = 2'b10; end
      S22: begin ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1; end
      S12: begin SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
      S4:  begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S21: begin ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1; end
      S6, S7: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S23: begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
      S16: Mem_WE = 1'b1;
      P1:  LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench: three sequencers (hold time 1, 2, 3) share stimulus; each
// cycle the full output word of one instance is compared against a table.
module tb_lc3_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       ir5 = 1'b0;
  logic       ben = 1'b0;
  logic [2:0][29:0] ow;

  int total = 0;
  int bad = 0;
  logic [29:0] exp_q[$];

  localparam logic [29:0] M_LD_MAR = 30'd1 << 0,  M_LD_MDR = 30'd1 << 1,
                          M_LD_IR  = 30'd1 << 2,  M_LD_BEN = 30'd1 << 3,
                          M_LD_CC  = 30'd1 << 4,  M_LD_REG = 30'd1 << 5,
                          M_LD_PC  = 30'd1 << 6,  M_LD_LED = 30'd1 << 7,
                          M_G_PC   = 30'd1 << 8,  M_G_MDR  = 30'd1 << 9,
                          M_G_ALU  = 30'd1 << 10, M_G_MARM = 30'd1 << 11,
                          M_PC_ADR = 30'd2 << 12, M_A1_SR1 = 30'd1 << 14,
                          M_A2_S6  = 30'd1 << 15, M_A2_S9  = 30'd2 << 15,
                          M_A2_S11 = 30'd3 << 15, M_DR_R7  = 30'd1 << 17,
                          M_SR1    = 30'd1 << 18, M_SR2    = 30'd1 << 19,
                          M_K_AND  = 30'd1 << 20, M_K_NOT  = 30'd2 << 20,
                          M_K_PASS = 30'd3 << 20, M_MIO    = 30'd1 << 22,
                          M_OE     = 30'd1 << 23, M_WE     = 30'd1 << 24;

  localparam logic [4:0] HALTED = 5'd0, S18 = 5'd1, S33 = 5'd2, S35 = 5'd3, S32 = 5'd4,
                         S1 = 5'd5, S5 = 5'd6, S9 = 5'd7, S0 = 5'd8, S22 = 5'd9,
                         S12 = 5'd10, S4 = 5'd11, S21 = 5'd12, S6 = 5'd13, S7 = 5'd14,
                         S25 = 5'd15, S27 = 5'd16, S23 = 5'd17, S16 = 5'd18,
                         P1 = 5'd19, P2 = 5'd20;

  localparam logic [29:0] E18   = M_G_PC | M_LD_MAR | M_LD_PC;
  localparam logic [29:0] ERD   = M_OE | M_MIO;
  localparam logic [29:0] ERDL  = M_OE | M_MIO | M_LD_MDR;
  localparam logic [29:0] E35   = M_G_MDR | M_LD_IR;
  localparam logic [29:0] EALU  = M_SR1 | M_G_ALU | M_LD_REG | M_LD_CC;
  localparam logic [29:0] EMEMA = M_SR1 | M_A1_SR1 | M_A2_S6 | M_G_MARM | M_LD_MAR;

  genvar k;
  for (k = 0; k < 3; k++) begin : g_dut
    lc3_control_fsm #(.MEM_WAIT_CYCLES(k + 1)) u_dut (
      .Clk(clk), .Reset(rst), .Run(run), .Continue(cont), .Opcode(opcode),
      .IR_5(ir5), .BEN(ben),
      .LD_MAR(ow[k][0]), .LD_MDR(ow[k][1]), .LD_IR(ow[k][2]), .LD_BEN(ow[k][3]),
      .LD_CC(ow[k][4]), .LD_REG(ow[k][5]), .LD_PC(ow[k][6]), .LD_LED(ow[k][7]),
      .GatePC(ow[k][8]), .GateMDR(ow[k][9]), .GateALU(ow[k][10]), .GateMARMUX(ow[k][11]),
      .PCMUX(ow[k][13:12]), .ADDR1MUX(ow[k][14]), .ADDR2MUX(ow[k][16:15]),
      .DRMUX(ow[k][17]), .SR1MUX(ow[k][18]), .SR2MUX(ow[k][19]), .ALUK(ow[k][21:20]),
      .MIO_EN(ow[k][22]), .Mem_OE(ow[k][23]), .Mem_WE(ow[k][24]),
      .State_dbg(ow[k][29:25])
    );
  end

  always #5 clk = ~clk;

  function automatic logic [29:0] w(input logic [4:0] s, input logic [29:0] bits);
    return bits | {s, 25'd0} | (ir5 ? M_SR2 : 30'd0);
  endfunction

  task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic play(input string tag, input int idx);
    foreach (exp_q[i]) begin
      tick;
      chk($sformatf("%s[%0d]", tag, i), ow[idx], exp_q[i]);
    end
  endtask

  task automatic start(input int idx);
    rst = 1'b1; run = 1'b0;
    tick;
    rst = 1'b0; run = 1'b1;
    tick;
    run = 1'b0;
    chk("start_s18", ow[idx], w(S18, E18));
  endtask

  initial begin
    // reset in the middle of S18
    start(0);
    #2 rst = 1'b1;
    #1 chk("rst_async", ow[0], 30'd0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk($sformatf("halted[%0d]", i), ow[0], 30'd0);
    end

    // ADD, immediate form, W=1
    opcode = 4'b0001; ir5 = 1'b1;
    start(0);
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S1, EALU), w(S18, E18)};
    play("add", 0);

    // AND, NOT, JMP, JSR, unknown opcode on W=1
    ir5 = 1'b0; opcode = 4'b0101;
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S5, EALU | M_K_AND), w(S18, E18)};
    play("and", 0);
    opcode = 4'b1001;
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S9, EALU | M_K_NOT), w(S18, E18)};
    play("not", 0);
    opcode = 4'b1100;
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN),
              w(S12, M_SR1 | M_A1_SR1 | M_PC_ADR | M_LD_PC), w(S18, E18)};
    play("jmp", 0);
    opcode = 4'b0100;
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S4, M_G_PC | M_DR_R7 | M_LD_REG),
              w(S21, M_A2_S11 | M_PC_ADR | M_LD_PC), w(S18, E18)};
    play("jsr", 0);
    opcode = 4'b1111;
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S18, E18)};
    play("nop", 0);

    // BR not taken, then taken
    opcode = 4'b0000; ben = 1'b0;
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S0, 30'd0), w(S18, E18)};
    play("br_nt", 0);
    ben = 1'b1;
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S0, 30'd0),
              w(S22, M_A2_S9 | M_PC_ADR | M_LD_PC), w(S18, E18)};
    play("br_t", 0);
    ben = 1'b0;

    // LDR with W=3: 11 cycles from S18 to the next S18
    opcode = 4'b0110;
    start(2);
    exp_q = '{w(S33, ERD), w(S33, ERD), w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN),
              w(S6, EMEMA), w(S25, ERD), w(S25, ERD), w(S25, ERDL),
              w(S27, M_G_MDR | M_LD_REG | M_LD_CC), w(S18, E18)};
    play("ldr_w3", 2);

    // STR with W=2
    opcode = 4'b0111;
    start(1);
    exp_q = '{w(S33, ERD), w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(S7, EMEMA),
              w(S23, M_K_PASS | M_G_ALU | M_LD_MDR), w(S16, M_WE), w(S16, M_WE), w(S18, E18)};
    play("str_w2", 1);

    // PAUSE: one advance per Continue press
    opcode = 4'b1101; cont = 1'b0;
    start(0);
    exp_q = '{w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(P1, M_LD_LED),
              w(P1, M_LD_LED), w(P1, M_LD_LED), w(P1, M_LD_LED), w(P1, M_LD_LED), w(P1, M_LD_LED)};
    play("p1_hold", 0);
    cont = 1'b1;
    exp_q = '{w(P2, 30'd0), w(P2, 30'd0), w(P2, 30'd0), w(P2, 30'd0)};
    play("p2_hold", 0);
    cont = 1'b0;
    exp_q = '{w(S18, E18), w(S33, ERDL), w(S35, E35), w(S32, M_LD_BEN), w(P1, M_LD_LED)};
    play("p_release", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_control_fsm.md
Name: lc3_control_fsm

Overview:
- Moore-style sequencer for the LC-3 datapath.
- Steps fetch, decode and execute for the lab instruction subset.
- Drives every register load enable, bus gate, mux select, ALU op and memory strobe in the datapath.
- Sits between the IR/BEN logic and the datapath muxes (PCMUX, ADDR1MUX, ADDR2MUX, DRMUX, SR1MUX, SR2MUX, MIO mux).

Parameters:
- MEM_WAIT_CYCLES, 1, number of cycles a memory access (read or write) holds its strobe; legal range 1..7.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  level; starts execution from HALTED.
- Continue  in  1  level; releases PAUSE.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  IR[5], immediate/register select.
- BEN  in  1  registered branch-enable from the datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
- PCMUX  out  2  00 = PC+1, 01 = bus, 10 = address adder.
- ADDR1MUX  out  1  0 = PC, 1 = SR1.
- ADDR2MUX  out  2  00 = 0, 01 = SEXT6, 10 = SEXT9, 11 = SEXT11.
- DRMUX  out  1  0 = IR[11:9], 1 = R7.
- SR1MUX  out  1  0 = IR[11:9], 1 = IR[8:6].
- SR2MUX  out  1  0 = SR2, 1 = SEXT5.
- ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT A, 11 = pass A.
- MIO_EN  out  1  0 = MDR loads from bus, 1 = MDR loads from memory.
- Mem_OE, Mem_WE  out  1 each  memory read and write strobes, active-high.
- State_dbg  out  5  current state encoding, for the debug display.

Behaviour:
- All outputs are combinational decodes of the current state only.
- Default value of every output is 0 in any state that does not assign it.
- SR2MUX = IR_5 in every state.
- Reset is asynchronous. Asserting it in any state (including mid-memory access) forces HALTED and clears the wait counter; all outputs read 0 immediately.
- Wait counter: width $clog2(MEM_WAIT_CYCLES+1). It loads 0 on entry to every memory state, and the state exits when count == MEM_WAIT_CYCLES-1.
- Memory read states (S33, S25):
  - Mem_OE=1 and MIO_EN=1 on every cycle.
  - LD_MDR=1 on the final cycle only.
- Memory write state (S16): Mem_WE=1 on every cycle.

State transitions and per-state outputs:
- HALTED: Run=1 -> S18; otherwise stay. Run is sampled only in HALTED.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC -> S33.
- S33: memory read -> S35.
- S35: GateMDR, LD_IR -> S32.
- S32: LD_BEN; decode Opcode:
  - 0001 -> S1; 0101 -> S5; 1001 -> S9; 0000 -> S0; 1100 -> S12; 0100 -> S4; 0110 -> S6; 0111 -> S7; 1101 -> P1.
  - Any other opcode -> S18 (treated as NOP).
- S1 / S5 / S9: SR1MUX=1, DRMUX=0, GateALU, LD_REG, LD_CC; ALUK = 00 / 01 / 10 respectively -> S18.
- S0: BEN=1 -> S22, else -> S18. BEN is the value latched in S32.
- S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
- S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S18.
- S4: GatePC, DRMUX=1, LD_REG -> S21.
- S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC -> S18.
  - In S4, R7 receives the already-incremented PC.
- S6 / S7: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> S25 / S23.
- S25: memory read -> S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC -> S18.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR -> S16.
- S16: memory write -> S18.
- P1: LD_LED; Continue=1 -> P2, else stay.
- P2: Continue=0 -> S18, else stay. Exactly one instruction advance per Continue press, regardless of hold length.

Latency and exclusivity:
- Cycles per instruction, with W = MEM_WAIT_CYCLES:
  - ADD/AND/NOT: 4+W.
  - BR not taken: 4+W; BR taken: 5+W.
  - JMP: 4+W.
  - JSR: 5+W.
  - LDR: 5+2W.
  - STR: 5+2W.
- Never: two Gate* high at once; Mem_OE and Mem_WE high at once.

Test Plan:
- Reset asserted mid-S18, all inputs 0 -> State_dbg = HALTED immediately, every output 0, stays in HALTED for 10 cycles with Run=0.
- W=1, Run pulsed, Opcode=0001, IR_5=1 -> states S18, S33, S35, S32, S1 on consecutive cycles. In S1: GateALU=1, LD_REG=1, LD_CC=1, ALUK=00, SR2MUX=1. Back in S18 on cycle 6.
- W=1, Opcode=0000: BEN=0 -> S0 then S18 (no LD_PC in S0). BEN=1 -> S22 with PCMUX=10, ADDR2MUX=10, LD_PC=1.
- W=3, Opcode=0110 -> Mem_OE high for exactly 3 cycles in S25, LD_MDR only on the 3rd, then S27 with GateMDR=1, LD_REG=1. Total 11 cycles from S18 to the next S18.
- W=2, Opcode=0111 -> S23 shows LD_MDR=1, MIO_EN=0, ALUK=11; S16 shows Mem_WE=1 for 2 cycles and Mem_OE=0 throughout.
- Opcode=1101: hold Continue=0 for 5 cycles -> stays P1 with LD_LED=1. Continue=1 for 4 cycles -> P2 held. Continue=0 -> next cycle S18, one fetch only.
